// File: rtl/spi_ram_param.sv
// Parametrised single-port RAM back end for the SPI slave, with tx_ready hold and range checking.
// Define SPI_RAM_AUTO_INC_EN to post-increment wr_addr on WRITE and rd_addr on accepted READ.
module spi_ram_param #(
  parameter  int DATA_W    = 8,
  parameter  int ADDR_W    = 8,
  parameter  int MEM_DEPTH = 256,
  localparam int PL_W      = (ADDR_W > DATA_W) ? ADDR_W : DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [PL_W+1:0]   din,
  input  logic              rx_valid,
  input  logic              tx_ready,
  output logic [DATA_W-1:0] dout,
  output logic              tx_valid,
  output logic              addr_err
);

  typedef enum logic [1:0] {
    OP_SET_WR = 2'b00,
    OP_WRITE  = 2'b01,
    OP_SET_RD = 2'b10,
    OP_READ   = 2'b11
  } op_t;

  typedef enum logic {
    IDLE    = 1'b0,
    TX_HOLD = 1'b1
  } state_t;

  // One extra bit so MEM_DEPTH == 2**ADDR_W is representable in the range compare.
  localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W+1)'(MEM_DEPTH);

  logic [DATA_W-1:0] mem [MEM_DEPTH];
  state_t            state, state_next;
  logic [ADDR_W-1:0] wr_addr, rd_addr, wr_addr_next, rd_addr_next;
  logic [ADDR_W-1:0] pl_addr;
  logic              addr_ok, err_next, rd_accept, wr_en;
  op_t               op;

  assign op       = op_t'(din[PL_W+1:PL_W]);
  assign pl_addr  = din[ADDR_W-1:0];
  assign addr_ok  = ({1'b0, pl_addr} < DEPTH_V);
  assign tx_valid = (state == TX_HOLD);

`ifdef SPI_RAM_AUTO_INC_EN
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(MEM_DEPTH - 1);

  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
    return (a == LAST) ? '0 : a + 1'b1;
  endfunction
`endif

  always_comb begin
    state_next   = state;
    wr_addr_next = wr_addr;
    rd_addr_next = rd_addr;
    err_next     = 1'b0;
    rd_accept    = 1'b0;
    wr_en        = 1'b0;
    if (state == TX_HOLD && tx_ready) state_next = IDLE;
    if (rx_valid) begin
      unique case (op)
        OP_SET_WR: begin
          if (addr_ok) wr_addr_next = pl_addr;
          else         err_next     = 1'b1;
        end
        OP_WRITE: begin
          wr_en = 1'b1;
`ifdef SPI_RAM_AUTO_INC_EN
          wr_addr_next = next_addr(wr_addr);
`endif
        end
        OP_SET_RD: begin
          if (addr_ok) rd_addr_next = pl_addr;
          else         err_next     = 1'b1;
        end
        OP_READ: begin
          // A READ while data is still held is dropped even if tx_ready frees it this cycle.
          if (state == IDLE) begin
            rd_accept  = 1'b1;
            state_next = TX_HOLD;
`ifdef SPI_RAM_AUTO_INC_EN
            rd_addr_next = next_addr(rd_addr);
`endif
          end else begin
            err_next = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      wr_addr  <= '0;
      rd_addr  <= '0;
      dout     <= '0;
      addr_err <= 1'b0;
    end else begin
      state    <= state_next;
      wr_addr  <= wr_addr_next;
      rd_addr  <= rd_addr_next;
      addr_err <= err_next;
      if (rd_accept) dout <= mem[rd_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= din[DATA_W-1:0];
  end

endmodule

// File: tb/tb_spi_ram_param.sv
// Bench for spi_ram_param: depth-256 and depth-200 instances share stimulus and are checked
// against a word-level model; expectations follow SPI_RAM_AUTO_INC_EN when it is defined.
module tb_spi_ram_param;

`ifdef SPI_RAM_AUTO_INC_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] din = '0;
  logic       rx_valid = 1'b0;
  logic       tx_ready = 1'b0;
  logic [7:0] dout_a, dout_b;
  logic       tx_valid_a, tx_valid_b, addr_err_a, addr_err_b;

  always #5 clk = ~clk;

  spi_ram_param #(.DATA_W(8), .ADDR_W(8), .MEM_DEPTH(256)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .din(din), .rx_valid(rx_valid), .tx_ready(tx_ready),
    .dout(dout_a), .tx_valid(tx_valid_a), .addr_err(addr_err_a)
  );

  spi_ram_param #(.DATA_W(8), .ADDR_W(8), .MEM_DEPTH(200)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .din(din), .rx_valid(rx_valid), .tx_ready(tx_ready),
    .dout(dout_b), .tx_valid(tx_valid_b), .addr_err(addr_err_b)
  );

  // Word-level reference model, one slot per instance
  int         dep [2] = '{256, 200};
  logic [7:0] m_mem   [2][256];
  bit         m_known [2][256];
  int         m_wr [2], m_rd [2];
  bit         m_busy [2], m_dk [2], m_err [2];
  logic [7:0] m_dout [2];

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic [1:0] op;
    logic [7:0] pl;
    bit         rxv;
    bit         txr;
    bit         cd;
    logic [7:0] ed;
    bit         etv;
    bit         eer;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(string name, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_wr[k] = 0; m_rd[k] = 0; m_busy[k] = 0;
      m_dout[k] = 8'h00; m_dk[k] = 1; m_err[k] = 0;
    end
  endtask

  task automatic model_step(int k);
    int pl;
    bit nb;
    pl = int'(din[7:0]);
    m_err[k] = 0;
    nb = m_busy[k] ? !tx_ready : 1'b0;
    if (rx_valid) begin
      case (din[9:8])
        2'b00: if (pl < dep[k]) m_wr[k] = pl; else m_err[k] = 1;
        2'b01: begin
          m_mem[k][m_wr[k]] = din[7:0];
          m_known[k][m_wr[k]] = 1;
          if (AUTO) m_wr[k] = (m_wr[k] + 1) % dep[k];
        end
        2'b10: if (pl < dep[k]) m_rd[k] = pl; else m_err[k] = 1;
        default: begin
          if (m_busy[k]) m_err[k] = 1;
          else begin
            m_dout[k] = m_mem[k][m_rd[k]];
            m_dk[k] = m_known[k][m_rd[k]];
            nb = 1;
            if (AUTO) m_rd[k] = (m_rd[k] + 1) % dep[k];
          end
        end
      endcase
    end
    m_busy[k] = nb;
  endtask

  task automatic cmp_model(string tag);
    chk({tag, " a.tx_valid"}, int'(tx_valid_a), int'(m_busy[0]));
    chk({tag, " a.addr_err"}, int'(addr_err_a), int'(m_err[0]));
    chk({tag, " b.tx_valid"}, int'(tx_valid_b), int'(m_busy[1]));
    chk({tag, " b.addr_err"}, int'(addr_err_b), int'(m_err[1]));
    if (m_dk[0]) chk({tag, " a.dout"}, int'(dout_a), int'(m_dout[0]));
    if (m_dk[1]) chk({tag, " b.dout"}, int'(dout_b), int'(m_dout[1]));
  endtask

  task automatic cyc(string tag, logic [1:0] op, logic [7:0] pl, bit rxv, bit txr);
    din = {op, pl}; rx_valid = rxv; tx_ready = txr;
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    cmp_model(tag);
  endtask

  initial begin
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 256; i++) begin
        m_mem[k][i] = 8'h00; m_known[k][i] = 0;
      end
    model_reset();

    // Reset state
    #2;
    chk("reset a.tx_valid", int'(tx_valid_a), 0);
    chk("reset a.dout", int'(dout_a), 0);
    chk("reset a.addr_err", int'(addr_err_a), 0);
    chk("reset b.tx_valid", int'(tx_valid_b), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset while holding read data
    cyc("t1", 2'b00, 8'h00, 1, 0);
    cyc("t1", 2'b01, 8'h3C, 1, 0);
    cyc("t1", 2'b10, 8'h00, 1, 0);
    cyc("t1", 2'b11, 8'h00, 1, 0);
    chk("t1 hold tx_valid", int'(tx_valid_a), 1);
    chk("t1 hold dout", int'(dout_a), 8'h3C);
    rx_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("t1 async tx_valid", int'(tx_valid_a), 0);
    chk("t1 async dout", int'(dout_a), 0);
    chk("t1 async b.tx_valid", int'(tx_valid_b), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cyc("t1 post", 2'b11, 8'h00, 1, 0);
    chk("t1 post dout", int'(dout_a), 8'h3C);
    cyc("t1 ack", 2'b00, 8'h00, 0, 1);

    // Write/read, hold, rejected read
    tbl.push_back('{2'b00, 8'h11, 1, 0, 0, 8'h00, 0, 0});
    tbl.push_back('{2'b01, 8'h66, 1, 0, 0, 8'h00, 0, 0});
    tbl.push_back('{2'b00, 8'h10, 1, 0, 0, 8'h00, 0, 0});
    tbl.push_back('{2'b01, 8'hA5, 1, 0, 0, 8'h00, 0, 0});
    tbl.push_back('{2'b10, 8'h10, 1, 0, 0, 8'h00, 0, 0});
    tbl.push_back('{2'b11, 8'h00, 1, 0, 1, 8'hA5, 1, 0});
    for (int i = 0; i < 5; i++)
      tbl.push_back('{2'b11, 8'h00, 0, 0, 1, 8'hA5, 1, 0});
    tbl.push_back('{2'b11, 8'h00, 1, 0, 1, 8'hA5, 1, 1});
    tbl.push_back('{2'b00, 8'h00, 0, 0, 1, 8'hA5, 1, 0});
    tbl.push_back('{2'b00, 8'h00, 0, 1, 1, 8'hA5, 0, 0});
    tbl.push_back('{2'b11, 8'h00, 1, 0, 1, AUTO ? 8'h66 : 8'hA5, 1, 0});
    tbl.push_back('{2'b11, 8'h00, 1, 1, 1, AUTO ? 8'h66 : 8'hA5, 0, 1});
    tbl.push_back('{2'b00, 8'h00, 0, 0, 1, AUTO ? 8'h66 : 8'hA5, 0, 0});
    for (int i = 0; i < tbl.size(); i++) begin
      cyc("tbl", tbl[i].op, tbl[i].pl, tbl[i].rxv, tbl[i].txr);
      chk($sformatf("tbl[%0d] tx_valid", i), int'(tx_valid_a), int'(tbl[i].etv));
      chk($sformatf("tbl[%0d] addr_err", i), int'(addr_err_a), int'(tbl[i].eer));
      if (tbl[i].cd) chk($sformatf("tbl[%0d] dout", i), int'(dout_a), int'(tbl[i].ed));
    end

    // Range check on depth 200, back-to-back errors
    cyc("t4", 2'b00, 8'h10, 1, 0);
    cyc("t4", 2'b00, 8'hC8, 1, 0);
    chk("t4 b.err C8", int'(addr_err_b), 1);
    chk("t4 a.err C8", int'(addr_err_a), 0);
    cyc("t4", 2'b00, 8'hC9, 1, 0);
    chk("t4 b.err b2b", int'(addr_err_b), 1);
    cyc("t4", 2'b01, 8'h5A, 1, 0);
    chk("t4 b.err clear", int'(addr_err_b), 0);
    cyc("t4", 2'b10, 8'h10, 1, 0);
    cyc("t4", 2'b11, 8'h00, 1, 0);
    chk("t4 b.dout kept wr_addr", int'(dout_b), 8'h5A);
    cyc("t4 ack", 2'b00, 8'h00, 0, 1);
    cyc("t4", 2'b00, 8'hC7, 1, 0);
    chk("t4 b.err C7", int'(addr_err_b), 0);

    // Auto-increment wrap on depth 200 (or legacy overwrite)
    cyc("t5", 2'b01, 8'h11, 1, 0);
    cyc("t5", 2'b01, 8'h22, 1, 0);
    cyc("t5", 2'b10, 8'hC7, 1, 0);
    cyc("t5", 2'b11, 8'h00, 1, 0);
    chk("t5 first read", int'(dout_b), AUTO ? 8'h11 : 8'h22);
    cyc("t5 ack", 2'b00, 8'h00, 0, 1);
    cyc("t5", 2'b11, 8'h00, 1, 0);
    chk("t5 second read", int'(dout_b), 8'h22);
    cyc("t5 ack", 2'b00, 8'h00, 0, 1);
    cyc("t5", 2'b10, 8'h00, 1, 0);
    cyc("t5", 2'b11, 8'h00, 1, 0);
    chk("t5 mem0", int'(dout_b), AUTO ? 8'h22 : 8'h3C);
    cyc("t5 ack", 2'b00, 8'h00, 0, 1);

    // Read one cycle after write to the same address
    cyc("raw", 2'b00, 8'h20, 1, 0);
    cyc("raw", 2'b10, 8'h20, 1, 0);
    cyc("raw", 2'b01, 8'h77, 1, 0);
    cyc("raw", 2'b11, 8'h00, 1, 0);
    chk("raw a.dout", int'(dout_a), 8'h77);
    chk("raw b.dout", int'(dout_b), 8'h77);
    cyc("raw ack", 2'b00, 8'h00, 0, 1);

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      logic [1:0] op;
      logic [7:0] pl;
      logic [7:0] edge_addr [4];
      edge_addr = '{8'd0, 8'd199, 8'd200, 8'd255};
      op = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) pl = edge_addr[$urandom_range(0, 3)];
      else pl = 8'($urandom_range(0, 255));
      cyc("rand", op, pl, ($urandom_range(0, 4) != 0), ($urandom_range(0, 1) == 1));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
